// File: rtl/button_event_decoder.sv
// button_event_decoder: synchronises, debounces and classifies two
// active-low buttons into short/long/double events behind a small FIFO.

module button_event_channel #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int LONG_CYCLES     = 12000000,
    parameter int GAP_CYCLES      = 6000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n_i,
    output logic       pressed_o,
    output logic [1:0] code_o
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TLIM = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TLIM + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DOWN, S_HELD, S_WAIT, S_DOWN2
    } state_t;

    logic          sync1_q, sync2_q;
    logic          synced;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          level_q, level_d;
    logic          rise, fall;
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          long_hit, gap_hit;

    // Two-flop synchroniser, idles at the released level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
        end
    end

    assign synced = ~sync2_q;

    // Debounce: count consecutive disagreeing cycles, flip on the last one.
    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (synced != level_q) begin
            if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = synced;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign rise     = level_d & ~level_q;
    assign fall     = ~level_d & level_q;
    assign long_hit = (timer_q == TW'(LONG_CYCLES - 1));
    assign gap_hit  = (timer_q == TW'(GAP_CYCLES - 1));

    // Debounce and gesture state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q <= '0;
            level_q  <= 1'b0;
            state_q  <= S_IDLE;
            timer_q  <= '0;
        end else begin
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
            state_q  <= state_d;
            timer_q  <= timer_d;
        end
    end

    // Gesture next state; timer restarts on every state change and saturates.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (rise) state_d = S_DOWN;
            S_DOWN:  if (fall) state_d = S_WAIT;
                     else if (long_hit) state_d = S_HELD;
            S_HELD:  if (fall) state_d = S_IDLE;
            S_WAIT:  if (rise) state_d = S_DOWN2;
                     else if (gap_hit) state_d = S_IDLE;
            S_DOWN2: if (fall) state_d = S_IDLE;
                     else if (long_hit) state_d = S_HELD;
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q == '1) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Gesture output: one-cycle event code, 00 when nothing is emitted.
    always_comb begin
        code_o = 2'b00;
        unique case (state_q)
            S_DOWN:  if (!fall && long_hit) code_o = 2'b10;
            S_WAIT:  if (!rise && gap_hit) code_o = 2'b01;
            S_DOWN2: if (fall || long_hit) code_o = 2'b11;
            default: code_o = 2'b00;
        endcase
    end

    assign pressed_o = level_q;
endmodule

module button_event_decoder #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int LONG_CYCLES     = 12000000,
    parameter int GAP_CYCLES      = 6000000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_a_n,
    input  logic       btn_b_n,
    output logic       pressed_a,
    output logic       pressed_b,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       evt_btn,
    output logic [1:0] evt_code,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]    code_a, code_b;
    logic          push_a, push_b, acc_a, acc_b, pop, drop;
    logic [2:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_q, wr_q, wr_b;
    logic [CW-1:0] cnt_q, cnt_d, free_slots;
    logic          ovf_q;

    button_event_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .LONG_CYCLES    (LONG_CYCLES),
        .GAP_CYCLES     (GAP_CYCLES)
    ) u_chan_a (
        .clk      (clk),
        .rst      (rst),
        .btn_n_i  (btn_a_n),
        .pressed_o(pressed_a),
        .code_o   (code_a)
    );

    button_event_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .LONG_CYCLES    (LONG_CYCLES),
        .GAP_CYCLES     (GAP_CYCLES)
    ) u_chan_b (
        .clk      (clk),
        .rst      (rst),
        .btn_n_i  (btn_b_n),
        .pressed_o(pressed_b),
        .code_o   (code_b)
    );

    assign push_a    = (code_a != 2'b00);
    assign push_b    = (code_b != 2'b00);
    assign evt_valid = (cnt_q != '0);
    assign pop       = evt_valid & evt_ready;

    // Admission: pop frees a slot first, then A, then B take what is left.
    always_comb begin
        free_slots = CW'(FIFO_DEPTH) - cnt_q + CW'(pop);
        acc_a      = push_a & (free_slots != '0);
        acc_b      = push_b & (free_slots > CW'(acc_a));
        drop       = (push_a & ~acc_a) | (push_b & ~acc_b);
        wr_b       = wr_q + AW'(acc_a);
        cnt_d      = cnt_q - CW'(pop) + CW'(acc_a) + CW'(acc_b);
    end

    // Event storage; B lands behind A when both are accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (acc_a && wr_q == AW'(i)) begin
                    mem_q[i] <= {1'b0, code_a};
                end else if (acc_b && wr_b == AW'(i)) begin
                    mem_q[i] <= {1'b1, code_b};
                end
            end
        end
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            rd_q  <= rd_q + AW'(pop);
            wr_q  <= wr_q + AW'(acc_a) + AW'(acc_b);
            cnt_q <= cnt_d;
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign {evt_btn, evt_code} = evt_valid ? mem_q[rd_q] : 3'b000;
    assign overflow            = ovf_q;
endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
Input-side companion to the board's RGB status-LED driver: it turns the two raw active-low push-buttons into clean, classified user events. Per button it performs:
- 2-FF synchronisation
- debouncing
- gesture classification (short, long, double press)

Events are queued in a small FIFO and presented on a valid/ready interface to the LED mode/colour controller.

Parameters:
DEBOUNCE_CYCLES, 240000, consecutive stable cycles required to accept a level change (10 ms @ 24 MHz)
LONG_CYCLES, 12000000, hold time that classifies a press as long (0.5 s)
GAP_CYCLES, 6000000, max released gap after a short press for a second press to count as double (0.25 s)
FIFO_DEPTH, 4, event queue entries; power of two, >= 2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
btn_a_n  in  1  raw button A, active-low, asynchronous to clk
btn_b_n  in  1  raw button B, active-low, asynchronous to clk
pressed_a  out  1  debounced level of A, 1 = held
pressed_b  out  1  debounced level of B, 1 = held
evt_valid  out  1  FIFO non-empty; head event presented
evt_ready  in  1  consumer accepts head when evt_valid && evt_ready
evt_btn  out  1  head event source: 0 = A, 1 = B
evt_code  out  2  01 short, 10 long, 11 double; 00 never presented while valid
overflow  out  1  sticky: an event was dropped; cleared only by rst

Behaviour:
- Clock and reset: the only clock is clk. rst is asynchronous, active-high.
- Reset values:
  - synchroniser flops = 1 (released)
  - pressed_a/b = 0, all FSMs IDLE, timers 0
  - FIFO empty, evt_valid = 0, evt_btn = 0, evt_code = 00, overflow = 0
- Synchroniser: two flops per button. The synced press is the inverse of the 2nd flop.
- Debounce, per button:
  - The counter clears whenever synced == debounced level.
  - Otherwise it increments each cycle.
  - The debounced level flips on the cycle the counter reaches DEBOUNCE_CYCLES-1, and the counter clears.
  - Latency from a clean raw edge to the pressed_x change is 2 + DEBOUNCE_CYCLES cycles.
  - Any glitch shorter than DEBOUNCE_CYCLES produces no change.
- Gesture FSM, per button, driven only by debounced rise/fall; the timer clears on every state entry:
  - IDLE: rise -> DOWN.
  - DOWN:
    - fall -> WAIT.
    - timer reaches LONG_CYCLES-1 -> emit LONG, go to HELD.
  - HELD: fall -> IDLE; no event.
  - WAIT:
    - rise -> DOWN2.
    - timer reaches GAP_CYCLES-1 -> emit SHORT, go to IDLE.
  - DOWN2:
    - fall -> emit DOUBLE, go to IDLE.
    - timer reaches LONG_CYCLES-1 -> emit DOUBLE, go to HELD.
    - No LONG event is ever produced from DOWN2.
  - Timers saturate and never wrap.
- Emit and FIFO push:
  - An emission is a 1-cycle push request.
  - The event is visible at the FIFO head no earlier than the next cycle.
  - The event-to-evt_valid latency is 1 cycle when the FIFO is empty.
- Simultaneous pushes from A and B in one cycle: A is written first, B second. With only one free slot, A is kept, B is dropped, and overflow is set.
- FIFO full:
  - A pop in the same cycle frees a slot for that cycle's push; pop is evaluated before push.
  - A push with no slot is dropped and overflow <= 1.
- FIFO order is strict arrival order. Head outputs are stable while evt_valid && !evt_ready.
- Buttons are fully independent; activity on one never alters the other's FSM.
- Reset mid-operation:
  - All state is lost and no events are generated.
  - A button held through reset release is seen as a fresh press after debounce.

Test Plan:
Benches use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, GAP_CYCLES=10, FIFO_DEPTH=4, evt_ready=1 unless stated.
1. Bounce: btn_a_n toggles every 2 cycles for 12 cycles, then is held low -> pressed_a rises exactly 6 cycles after the last edge, with no intermediate pulses.
2. Short: A held 8 cycles debounced, then released -> GAP_CYCLES cycles after the debounced fall, a single event btn=0 code=01 appears with evt_valid for 1 cycle.
3. Long: B held 30 cycles -> btn=1 code=10 is pushed on the 20th debounced-held cycle, and the release produces nothing.
4. Double: A press 5, release 5, press 5, release -> a single event btn=0 code=11 on the 2nd debounced fall; no SHORT event.
5. Simultaneous: evt_ready=0; A and B short presses with identical timing -> 2 entries, A(01) at head then B(01); raising evt_ready pops A then B on consecutive cycles.
6. Overflow/reset: evt_ready=0 and 5 events generated -> 4 queued and overflow=1. Assert rst mid-press of A -> all outputs at reset values immediately, and no event after rst deasserts until a fresh debounced press.
